placar_conv_scheduler: RTL and testbench
========================================

// Module: placar_conv_scheduler
// PURPOSE
//  Scoreboard score keeper and scheduler for the shared 7-bit binary-to-BCD converter.
//  Holds the two team scores and accepts score events over a valid/ready port.
//  Time-multiplexes the single combinational converter between team A and team B.
//  Latches each converted BCD pair into per-team display registers.
//  Sits between the button/debounce logic and the 7-segment decoders.
// PARAMETERS
//  MAX_SCORE   99  saturation ceiling for each score; must be <= 99
//  SETTLE_CYC  1   cycles conv_bin is held stable before capture; range 1..7
// PORTS
//  clk          in   1  single system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  clr_i        in   1  one-cycle pulse: zero both scores
//  ev_valid     in   1  score event present
//  ev_ready     out  1  event accepted on an edge where ev_valid & ev_ready
//  ev_team      in   1  0 = team A, 1 = team B
//  ev_op        in   2  00 = +1, 01 = +2, 10 = +3, 11 = -1
//  undo_i       in   1  one-cycle pulse: revert last accepted event (see CONFIGURATION)
//  conv_bin     out  7  binary operand to the shared converter (registered)
//  conv_bcd     in   8  converter result {tens, units}
//  conv_over99  in   1  converter >99 flag
//  score_a      out  7  team A binary score
//  score_b      out  7  team B binary score
//  disp_a       out  8  team A BCD, stable between captures
//  disp_b       out  8  team B BCD, stable between captures
//  busy         out  1  a conversion is pending or in progress
//  err_over99   out  1  sticky: conv_over99 was seen at a capture edge
// BEHAVIOUR
//  Reset:
//   - All of the following are 0: score_a/b, disp_a/b, conv_bin, busy, err_over99, dirty_a/b, undo_vld, rr_last.
//   - State resets to IDLE.
//  Handshake:
//   - ev_ready = ~clr_i (& ~undo_i when the undo feature is compiled in); purely combinational.
//  Score update (on the accepting edge):
//   - Add: score <= min(score + n, MAX_SCORE).
//   - -1 at score 0: score stays 0.
//   - dirty_x is set only if the score value changes.
//  FSM states:
//   - IDLE: if any dirty flag is set, pick a team.
//     - Pick rule: only one dirty -> that team; both dirty -> the team != rr_last.
//     - On the pick edge: conv_bin <= score_x, sel <= x, dirty_x <= 0, cnt <= 0, go to CONV.
//   - CONV: cnt increments each cycle.
//     - When cnt == SETTLE_CYC-1: disp_sel <= conv_bcd, err_over99 |= conv_over99, rr_last <= sel.
//     - Same edge: go back to IDLE, or straight to a new pick if a dirty flag is set.
//  Latency:
//   - Event accepted at edge k (no contention) -> conv_bin loaded at edge k+1.
//   - disp updated at edge k+1+SETTLE_CYC.
//  Same-team event during CONV:
//   - The set of dirty_x wins over its clear; the old value still completes.
//   - A reconversion of that team follows.
//  busy = (state != IDLE) | dirty_a | dirty_b.
//  clr_i:
//   - Next edge: scores <= 0, dirty_a = dirty_b = 1, err_over99 <= 0, undo_vld <= 0.
//   - Any CONV in progress is aborted with no capture; state goes to IDLE.
//   - clr_i has priority over events and undo.
//  Both teams independent: conv_bin only changes on a pick edge.
// CONFIGURATION
//  Macro: PLACAR_UNDO_EN.
//  Defined:
//   - Each accepted event stores {team, previous score} and sets undo_vld.
//   - undo_i with undo_vld: restore the stored score, set dirty for that team, clear undo_vld.
//   - undo_i without undo_vld: no effect.
//   - undo_i has priority over ev_valid in the same cycle (ev_ready = 0).
//  Not defined:
//   - undo_i is ignored and ev_ready = ~clr_i.
//   - No undo storage is built.
// TESTING
//  1. Reset, SETTLE_CYC=1, A +3 at edge k -> score_a=3, conv_bin=3 at k+1, disp_a=8'h03 at k+2, busy low at k+2.
//  2. A=98, then +3 -> score_a=99, disp_a=8'h99. Next, B at 0 gets -1 -> score_b=0, busy stays 0.
//  3. A +1 and B +2 in back-to-back cycles -> A converted first, then B. With both dirty and rr_last=A, B is served first.
//  4. A +1 during A's CONV (SETTLE_CYC=3) -> disp_a shows the old value, then the new value one conversion later.
//  5. clr_i mid-CONV with ev_valid=1 -> ev_ready=0, no capture, scores 0, disp_a=disp_b=8'h00 after both reconvert.
//  6. PLACAR_UNDO_EN: B=10, +2, then undo_i -> score_b=10, disp_b=8'h10. A second undo_i has no effect.
//     Stub conv_over99=1 -> err_over99 stays set until clr_i.

Source files
------------

// File: rtl/placar_conv_scheduler_if.sv
// rtl/placar_conv_scheduler_if.sv - score event valid/ready port shared by the keeper and its event source
interface placar_conv_scheduler_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_team;
  logic [1:0] ev_op;

  modport master (output ev_valid, ev_team, ev_op, input ev_ready);
  modport slave  (input ev_valid, ev_team, ev_op, output ev_ready);
endinterface

// File: rtl/placar_conv_scheduler.sv
// rtl/placar_conv_scheduler.sv - two-team score keeper time-sharing one bin-to-BCD converter
// Optional undo of the last accepted event is built when PLACAR_UNDO_EN is defined.
module placar_conv_scheduler #(
  parameter int MAX_SCORE  = 99,
  parameter int SETTLE_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    undo_i,
  placar_conv_scheduler_if.slave  ev,
  output logic [6:0]              conv_bin,
  input  logic [7:0]              conv_bcd,
  input  logic                    conv_over99,
  output logic [6:0]              score_a,
  output logic [6:0]              score_b,
  output logic [7:0]              disp_a,
  output logic [7:0]              disp_b,
  output logic                    busy,
  output logic                    err_over99
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       sel, rr_last, dirty_a, dirty_b;
  logic       accept, conv_done, pick_vld, pick_team, pick_go;
  logic [6:0] cur, upd, nxt_a, nxt_b;
  logic       set_a, set_b;
  logic       undo_do, undo_team;
  logic [6:0] undo_score;

  function automatic logic [6:0] apply_op(input logic [6:0] s, input logic [1:0] op);
    logic [7:0] sum;
    if (op == 2'b11) return (s == 7'd0) ? 7'd0 : s - 7'd1;
    sum = {1'b0, s} + {6'd0, op} + 8'd1;
    return (sum > 8'(MAX_SCORE)) ? 7'(MAX_SCORE) : sum[6:0];
  endfunction

  assign accept    = ev.ev_valid & ev.ev_ready;
  assign cur       = ev.ev_team ? score_b : score_a;
  assign upd       = apply_op(cur, ev.ev_op);
  assign pick_vld  = dirty_a | dirty_b;
  assign pick_team = (dirty_a & dirty_b) ? ~rr_last : dirty_b;
  assign conv_done = (state == CONV) && (cnt == 3'(SETTLE_CYC - 1));
  assign pick_go   = ~clr_i & pick_vld & ((state == IDLE) | conv_done);

`ifdef PLACAR_UNDO_EN
  logic undo_vld;

  assign undo_do = undo_i & undo_vld & ~clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      undo_vld   <= 1'b0;
      undo_team  <= 1'b0;
      undo_score <= 7'd0;
    end else if (clr_i || undo_do) begin
      undo_vld   <= 1'b0;
    end else if (accept) begin
      undo_vld   <= 1'b1;
      undo_team  <= ev.ev_team;
      undo_score <= cur;
    end
  end
`else
  logic unused_undo;

  assign unused_undo = undo_i;
  assign undo_do     = 1'b0;
  assign undo_team   = 1'b0;
  assign undo_score  = 7'd0;
`endif

  // Clear beats undo beats a new event; dirty only marks real value changes.
  always_comb begin
    nxt_a = score_a;
    nxt_b = score_b;
    set_a = 1'b0;
    set_b = 1'b0;
    if (clr_i) begin
      nxt_a = 7'd0;
      nxt_b = 7'd0;
      set_a = 1'b1;
      set_b = 1'b1;
    end else if (undo_do) begin
      if (undo_team) begin
        nxt_b = undo_score;
        set_b = 1'b1;
      end else begin
        nxt_a = undo_score;
        set_a = 1'b1;
      end
    end else if (accept) begin
      if (ev.ev_team) begin
        nxt_b = upd;
        set_b = (upd != score_b);
      end else begin
        nxt_a = upd;
        set_a = (upd != score_a);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_i)          state_nxt = IDLE;
    else if (pick_go)   state_nxt = CONV;
    else if (conv_done) state_nxt = IDLE;
  end

  always_comb begin
`ifdef PLACAR_UNDO_EN
    ev.ev_ready = ~clr_i & ~undo_i;
`else
    ev.ev_ready = ~clr_i;
`endif
    busy = (state != IDLE) | dirty_a | dirty_b;
  end

  // A set of dirty on the pick edge outlives the clear, forcing a reconversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_a    <= 7'd0;
      score_b    <= 7'd0;
      dirty_a    <= 1'b0;
      dirty_b    <= 1'b0;
      conv_bin   <= 7'd0;
      sel        <= 1'b0;
      cnt        <= 3'd0;
      disp_a     <= 8'd0;
      disp_b     <= 8'd0;
      err_over99 <= 1'b0;
      rr_last    <= 1'b0;
    end else begin
      score_a <= nxt_a;
      score_b <= nxt_b;
      dirty_a <= set_a | (dirty_a & ~(pick_go & ~pick_team));
      dirty_b <= set_b | (dirty_b & ~(pick_go & pick_team));
      if (pick_go) begin
        conv_bin <= pick_team ? score_b : score_a;
        sel      <= pick_team;
        cnt      <= 3'd0;
      end else if (state == CONV) begin
        cnt <= cnt + 3'd1;
      end
      if (clr_i) begin
        err_over99 <= 1'b0;
      end else if (conv_done) begin
        if (sel) disp_b <= conv_bcd;
        else     disp_a <= conv_bcd;
        err_over99 <= err_over99 | conv_over99;
        rr_last    <= sel;
      end
    end
  end

endmodule

// File: tb/tb_placar_conv_scheduler.sv
// tb/tb_placar_conv_scheduler.sv - bench for placar_conv_scheduler with SETTLE_CYC 1 and 3 instances
module tb_placar_conv_scheduler;
  logic       clk = 1'b0;
  logic       rst_n, clr_i, undo_i, ev_valid, ev_team, over99;
  logic [1:0] ev_op;
  int         n_chk, n_fail;

  logic [6:0] conv_bin1, score_a1, score_b1, conv_bin3, score_a3, score_b3;
  logic [7:0] disp_a1, disp_b1, disp_a3, disp_b3;
  logic       busy1, err1, busy3, err3;

  logic [6:0] ms [2];
  logic [7:0] md [2];
  logic [7:0] expq [4][$];
  logic [7:0] prev [4];
  logic [7:0] dsp [4];

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  placar_conv_scheduler_if if1();
  placar_conv_scheduler_if if3();
  assign if1.ev_valid = ev_valid;
  assign if1.ev_team  = ev_team;
  assign if1.ev_op    = ev_op;
  assign if3.ev_valid = ev_valid;
  assign if3.ev_team  = ev_team;
  assign if3.ev_op    = ev_op;

  placar_conv_scheduler #(.MAX_SCORE(99), .SETTLE_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .undo_i(undo_i), .ev(if1),
    .conv_bin(conv_bin1), .conv_bcd(bcd(conv_bin1)), .conv_over99(over99),
    .score_a(score_a1), .score_b(score_b1), .disp_a(disp_a1), .disp_b(disp_b1),
    .busy(busy1), .err_over99(err1));

  placar_conv_scheduler #(.MAX_SCORE(99), .SETTLE_CYC(3)) u3 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .undo_i(undo_i), .ev(if3),
    .conv_bin(conv_bin3), .conv_bcd(bcd(conv_bin3)), .conv_over99(over99),
    .score_a(score_a3), .score_b(score_b3), .disp_a(disp_a3), .disp_b(disp_b3),
    .busy(busy3), .err_over99(err3));

  assign dsp[0] = disp_a1;
  assign dsp[1] = disp_b1;
  assign dsp[2] = disp_a3;
  assign dsp[3] = disp_b3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input logic team, input logic [6:0] v);
    ms[team] = v;
    if (bcd(v) != md[team]) begin
      md[team] = bcd(v);
      expq[team].push_back(bcd(v));
      expq[2 + team].push_back(bcd(v));
    end
  endtask

  task automatic model_ev(input logic team, input logic [1:0] op);
    int s;
    s = ms[team];
    if (op == 2'b11) s = (s == 0) ? 0 : s - 1;
    else             s = (s + op + 1 > 99) ? 99 : s + op + 1;
    push_disp(team, 7'(s));
  endtask

  task automatic drive(input logic team, input logic [1:0] op, input bit upd);
    ev_valid = 1'b1;
    ev_team  = team;
    ev_op    = op;
    #1;
    chk("ev_ready1", if1.ev_ready, 1);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    if (upd) model_ev(team, op);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      step();
      if (!busy1 && !busy3) break;
    end
    chk("idle_timeout", {busy1, busy3}, 0);
  endtask

  // Scoreboard: every display change must match the next expected value for that team.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) prev[i] = 8'h00;
      else if (dsp[i] !== prev[i]) begin
        prev[i] = dsp[i];
        if (expq[i].size() == 0) chk($sformatf("scb_unexpected_%0d", i), dsp[i], 32'hffff_ffff);
        else chk($sformatf("scb_disp_%0d", i), dsp[i], expq[i].pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; clr_i = 1'b0; undo_i = 1'b0; ev_valid = 1'b0; ev_team = 1'b0; ev_op = 2'b00;
    over99 = 1'b0;
    ms[0] = 0; ms[1] = 0; md[0] = 8'h00; md[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_score_a", score_a1, 0);
    chk("rst_score_b", score_b1, 0);
    chk("rst_disp", {disp_a1, disp_b1, disp_a3, disp_b3}, 0);
    chk("rst_conv_bin", conv_bin1, 0);
    chk("rst_busy", {busy1, busy3}, 0);
    chk("rst_err", {err1, err3}, 0);

    // single event latency
    drive(0, 2'b10, 1);
    chk("t1_score_a", score_a1, 3);
    chk("t1_conv_hold", conv_bin1, 0);
    step();
    chk("t1_conv_bin", conv_bin1, 3);
    chk("t1_busy", busy1, 1);
    step();
    chk("t1_disp_a", disp_a1, 8'h03);
    chk("t1_busy_low", busy1, 0);
    wait_idle();

    // decrement at zero is a no-op
    drive(1, 2'b11, 1);
    chk("t2_score_b0", score_b1, 0);
    chk("t2_busy_b0", {busy1, busy3}, 0);

    // interleaved teams, same-team event during conversion, round robin
    drive(0, 2'b00, 1);
    drive(1, 2'b01, 1);
    chk("t3_conv1_a", conv_bin1, 4);
    chk("t3_conv3_a", conv_bin3, 4);
    drive(0, 2'b10, 1);
    chk("t3_conv1_b", conv_bin1, 2);
    chk("t3_disp1_a", disp_a1, 8'h04);
    step();
    step();
    chk("t4_disp3_old", disp_a3, 8'h04);
    chk("t3_rr_b_first", conv_bin3, 2);
    wait_idle();
    chk("t4_disp_new", {disp_a1, disp_a3}, 16'h0707);
    chk("t3_disp_b", {disp_b1, disp_b3}, 16'h0202);

    // saturation
    for (int i = 0; i < 30; i++) begin
      drive(0, 2'b10, 1);
      wait_idle();
    end
    drive(0, 2'b00, 1);
    wait_idle();
    chk("t2_score_98", score_a1, 98);
    drive(0, 2'b10, 1);
    chk("t2_sat", {score_a1, score_a3}, {7'd99, 7'd99});
    wait_idle();
    chk("t2_disp_99", {disp_a1, disp_a3}, 16'h9999);

    // clear aborts a conversion in flight and wins over an event
    drive(0, 2'b11, 0);
    step();
    clr_i = 1'b1; ev_valid = 1'b1; ev_team = 1'b1; ev_op = 2'b00;
    #1;
    chk("t5_ready_clr", {if1.ev_ready, if3.ev_ready}, 0);
    step();
    clr_i = 1'b0; ev_valid = 1'b0;
    chk("t5_scores", {score_a1, score_b1, score_a3, score_b3}, 0);
    chk("t5_busy", busy1, 1);
    push_disp(0, 0);
    push_disp(1, 0);
    wait_idle();
    chk("t5_disp", {disp_a1, disp_b1, disp_a3, disp_b3}, 0);

    // sticky converter overflow flag
    over99 = 1'b1;
    drive(0, 2'b00, 1);
    wait_idle();
    over99 = 1'b0;
    chk("t6_err_set", {err1, err3}, 2'b11);
    drive(0, 2'b00, 1);
    wait_idle();
    chk("t6_err_sticky", {err1, err3}, 2'b11);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t6_err_clr", {err1, err3}, 0);
    push_disp(0, 0);
    push_disp(1, 0);
    wait_idle();

`ifdef PLACAR_UNDO_EN
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, 1);
      wait_idle();
    end
    drive(1, 2'b00, 1);
    wait_idle();
    drive(1, 2'b01, 1);
    wait_idle();
    chk("u_score_12", score_b1, 12);
    undo_i = 1'b1; ev_valid = 1'b1; ev_team = 1'b0; ev_op = 2'b00;
    #1;
    chk("u_ready_low", if1.ev_ready, 0);
    step();
    undo_i = 1'b0; ev_valid = 1'b0;
    push_disp(1, 10);
    chk("u_score_b", {score_b1, score_b3}, {7'd10, 7'd10});
    chk("u_event_blocked", score_a1, ms[0]);
    wait_idle();
    chk("u_disp_b", {disp_b1, disp_b3}, 16'h1010);
    undo_i = 1'b1;
    step();
    undo_i = 1'b0;
    chk("u_second_noop", score_b1, 10);
    chk("u_second_busy", busy1, 0);
`endif

    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("scb_left_%0d", i), expq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
